// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide in / 2-wide out circular instruction queue between fetch and decode (option macro FETCHQ_BYPASS_EN).
// Latency: a bundle enqueued in cycle N is presented at deq_* in cycle N+1; with FETCHQ_BYPASS_EN an empty queue forwards in the same cycle.
// Backpressure: enq_ready drops when fewer than 2 slots are free; dec_ready stalls dequeue; prmiss flushes everything.
`timescale 1ns/1ps

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif

module fetch_queue #(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq_valid,
    input  logic [`ADDR_LEN-1:0] enq_pc,
    input  logic [`INSN_LEN-1:0] enq_inst1,
    input  logic [`INSN_LEN-1:0] enq_inst2,
    input  logic                 enq_invalid2,
    output logic                 enq_ready,
    input  logic                 prmiss,
    input  logic                 dec_ready,
    output logic                 deq_valid1,
    output logic                 deq_valid2,
    output logic [`INSN_LEN-1:0] deq_inst1,
    output logic [`INSN_LEN-1:0] deq_inst2,
    output logic [`ADDR_LEN-1:0] deq_pc1,
    output logic [`ADDR_LEN-1:0] deq_pc2
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(QUEUE_DEPTH - 2);

    logic [`INSN_LEN-1:0] inst_mem [QUEUE_DEPTH];
    logic [`ADDR_LEN-1:0] pc_mem   [QUEUE_DEPTH];

    logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
    logic [CNT_W-1:0] count, enq_n, deq_n;
    logic             q_vld1, q_vld2;
    logic             enq_fire, wr_en, deq_fire;
    logic [`ADDR_LEN-1:0] enq_pc2;

    assign head_p1   = head + PTR_W'(1);
    assign tail_p1   = tail + PTR_W'(1);
    assign enq_pc2   = enq_pc + `ADDR_LEN'(4);
    assign q_vld1    = (count != '0);
    assign q_vld2    = (count >= CNT_W'(2));

    // Readiness looks only at the current occupancy; a same-cycle dequeue is not credited.
    assign enq_ready = (count <= ENQ_LIMIT);
    assign enq_fire  = enq_valid && enq_ready && !prmiss;

`ifdef FETCHQ_BYPASS_EN
    logic byp_act, byp_take;

    assign byp_act  = (count == '0) && enq_valid && !prmiss;
    assign byp_take = byp_act && dec_ready;

    always_comb begin
        deq_valid1 = q_vld1 && !prmiss;
        deq_valid2 = q_vld2 && !prmiss;
        deq_inst1  = inst_mem[head];
        deq_inst2  = inst_mem[head_p1];
        deq_pc1    = pc_mem[head];
        deq_pc2    = pc_mem[head_p1];
        if (byp_act) begin
            deq_valid1 = 1'b1;
            deq_valid2 = !enq_invalid2;
            deq_inst1  = enq_inst1;
            deq_inst2  = enq_inst2;
            deq_pc1    = enq_pc;
            deq_pc2    = enq_pc2;
        end
    end

    // A bundle taken straight by decode never touches storage.
    assign wr_en    = enq_fire && !byp_take;
    assign deq_fire = dec_ready && q_vld1 && !prmiss;
`else
    assign deq_valid1 = q_vld1 && !prmiss;
    assign deq_valid2 = q_vld2 && !prmiss;
    assign deq_inst1  = inst_mem[head];
    assign deq_inst2  = inst_mem[head_p1];
    assign deq_pc1    = pc_mem[head];
    assign deq_pc2    = pc_mem[head_p1];

    assign wr_en    = enq_fire;
    assign deq_fire = dec_ready && deq_valid1;
`endif

    always_comb begin
        enq_n = '0;
        deq_n = '0;
        if (wr_en)
            enq_n = enq_invalid2 ? CNT_W'(1) : CNT_W'(2);
        if (deq_fire)
            deq_n = q_vld2 ? CNT_W'(2) : CNT_W'(1);
    end

    // Storage is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem[tail] <= enq_inst1;
            pc_mem[tail]   <= enq_pc;
            if (!enq_invalid2) begin
                inst_mem[tail_p1] <= enq_inst2;
                pc_mem[tail_p1]   <= enq_pc2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (prmiss) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_n[PTR_W-1:0];
            tail  <= tail + enq_n[PTR_W-1:0];
            count <= count + enq_n - deq_n;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected {inst,pc} pairs, a negedge monitor pops them as decode consumes.
`timescale 1ns/1ps

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_pc = '0;
    logic [31:0] enq_inst1 = '0;
    logic [31:0] enq_inst2 = '0;
    logic        enq_invalid2 = 1'b0;
    logic        enq_ready;
    logic        prmiss = 1'b0;
    logic        dec_ready = 1'b0;
    logic        deq_valid1, deq_valid2;
    logic [31:0] deq_inst1, deq_inst2, deq_pc1, deq_pc2;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    fetch_queue #(.QUEUE_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst1(enq_inst1), .enq_inst2(enq_inst2),
        .enq_invalid2(enq_invalid2), .enq_ready(enq_ready),
        .prmiss(prmiss), .dec_ready(dec_ready),
        .deq_valid1(deq_valid1), .deq_valid2(deq_valid2),
        .deq_inst1(deq_inst1), .deq_inst2(deq_inst2),
        .deq_pc1(deq_pc1), .deq_pc2(deq_pc2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins1(input logic [31:0] pc);
        return {16'h1A00, pc[15:0]};
    endfunction

    function automatic logic [31:0] ins2(input logic [31:0] pc);
        return {16'h2B00, pc[15:0]};
    endfunction

    // One cycle: drive inputs just after the rising edge, return at the falling edge for checks.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                       input logic inv2, input logic dr, input logic pm, input logic push);
        @(posedge clk);
        #1;
        enq_valid    = v;
        enq_pc       = pc;
        enq_inst1    = i1;
        enq_inst2    = i2;
        enq_invalid2 = inv2;
        dec_ready    = dr;
        prmiss       = pm;
        if (push) begin
            exp_q.push_back({i1, pc});
            if (!inv2) exp_q.push_back({i2, pc + 32'd4});
        end
        @(negedge clk);
    endtask

    task automatic enq(input logic [31:0] pc, input logic inv2, input logic dr);
        cyc(1'b1, pc, ins1(pc), ins2(pc), inv2, dr, 1'b0, 1'b1);
    endtask

    task automatic idle(input logic dr);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, dr, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (dut.count == '0) break;
            idle(1'b1);
        end
        chk("drain_empty", 64'(dut.count), 64'd0);
    endtask

    task automatic pop_cmp(input string name, input logic [63:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected nothing (scoreboard empty)", name, act);
        end else begin
            chk(name, act, exp_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (reset && deq_valid1 && dec_ready) begin
            pop_cmp("deq_slot1", {deq_inst1, deq_pc1});
            if (deq_valid2) pop_cmp("deq_slot2", {deq_inst2, deq_pc2});
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        // Reset state, observed with no clock edge involved
        #12;
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_deq_valid1", 64'(deq_valid1), 64'd0);
        chk("rst_deq_valid2", 64'(deq_valid2), 64'd0);
        chk("rst_count", 64'(dut.count), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // First bundle visible next cycle
        cyc(1'b1, 32'h100, 32'hA, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1);
`ifndef FETCHQ_BYPASS_EN
        chk("no_bypass_valid1", 64'(deq_valid1), 64'd0);
`endif
        idle(1'b0);
        chk("first_valid1", 64'(deq_valid1), 64'd1);
        chk("first_valid2", 64'(deq_valid2), 64'd1);
        chk("first_pc1", 64'(deq_pc1), 64'h100);
        chk("first_pc2", 64'(deq_pc2), 64'h104);
        chk("first_inst1", 64'(deq_inst1), 64'hA);
        chk("first_inst2", 64'(deq_inst2), 64'hB);
        chk("first_count", 64'(dut.count), 64'd2);
        drain();

        // Fill to full, ignore an extra bundle, drain in order
        for (int b = 0; b < 4; b++) begin
            enq(32'h200 + 32'(b * 8), 1'b0, 1'b0);
            chk("fill_enq_ready", 64'(enq_ready), 64'd1);
        end
        idle(1'b0);
        chk("full_count", 64'(dut.count), 64'd8);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        cyc(1'b1, 32'h300, ins1(32'h300), ins2(32'h300), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("full_ignored_count", 64'(dut.count), 64'd8);
        for (int k = 0; k < 4; k++) idle(1'b1);
        idle(1'b0);
        chk("full_drained_count", 64'(dut.count), 64'd0);

        // Single-entry enqueue concurrent with single-entry dequeue
        enq(32'h400, 1'b1, 1'b0);
        enq(32'h500, 1'b1, 1'b1);
        chk("simul_valid2", 64'(deq_valid2), 64'd0);
        idle(1'b0);
        chk("simul_count", 64'(dut.count), 64'd1);
        chk("simul_valid2_after", 64'(deq_valid2), 64'd0);
        chk("simul_pc1", 64'(deq_pc1), 64'h500);
        drain();

        // Bundle straddling the wrap point
        enq(32'h600, 1'b1, 1'b0);
        enq(32'h610, 1'b0, 1'b0);
        idle(1'b0);
        chk("wrap_tail_before", 64'(dut.tail), 64'd7);
        enq(32'h700, 1'b0, 1'b0);
        idle(1'b0);
        chk("wrap_pc_idx7", 64'(dut.pc_mem[7]), 64'h700);
        chk("wrap_pc_idx0", 64'(dut.pc_mem[0]), 64'h704);
        chk("wrap_inst_idx0", 64'(dut.inst_mem[0]), 64'(ins2(32'h700)));
        chk("wrap_tail_after", 64'(dut.tail), 64'd1);
        chk("wrap_count", 64'(dut.count), 64'd5);
        drain();

        // Mispredict flush beats concurrent enqueue and dequeue
        enq(32'h800, 1'b0, 1'b0);
        enq(32'h808, 1'b0, 1'b0);
        enq(32'h810, 1'b0, 1'b0);
        cyc(1'b1, 32'h900, ins1(32'h900), ins2(32'h900), 1'b0, 1'b1, 1'b1, 1'b0);
        chk("flush_valid1", 64'(deq_valid1), 64'd0);
        chk("flush_valid2", 64'(deq_valid2), 64'd0);
        exp_q.delete();
        idle(1'b0);
        chk("flush_count", 64'(dut.count), 64'd0);
        chk("flush_enq_ready", 64'(enq_ready), 64'd1);
        chk("flush_head", 64'(dut.head), 64'd0);
        chk("flush_tail", 64'(dut.tail), 64'd0);

        // Asynchronous reset mid-operation
        enq(32'hA00, 1'b0, 1'b0);
        idle(1'b0);
        chk("pre_reset_valid1", 64'(deq_valid1), 64'd1);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_valid1", 64'(deq_valid1), 64'd0);
        chk("async_rst_count", 64'(dut.count), 64'd0);
        chk("async_rst_enq_ready", 64'(enq_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        enq(32'hB00, 1'b0, 1'b0);
        idle(1'b0);
        chk("post_rst_idx0", 64'(dut.pc_mem[0]), 64'hB00);
        chk("post_rst_tail", 64'(dut.tail), 64'd2);
        drain();

`ifdef FETCHQ_BYPASS_EN
        // Empty-queue bypass consumed in the same cycle
        enq(32'h200, 1'b0, 1'b1);
        chk("byp_valid1", 64'(deq_valid1), 64'd1);
        chk("byp_pc1", 64'(deq_pc1), 64'h200);
        chk("byp_valid2", 64'(deq_valid2), 64'd1);
        chk("byp_pc2", 64'(deq_pc2), 64'h204);
        idle(1'b0);
        chk("byp_count", 64'(dut.count), 64'd0);
        chk("byp_valid1_after", 64'(deq_valid1), 64'd0);
`endif

        idle(1'b0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: QUEUE_DEPTH, 8, entry count; power of two, >=4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset==0 asserts).
REQ-004 enq_valid  input  1  fetch stage presents a bundle this cycle.
REQ-005 enq_pc  input  `ADDR_LEN  PC of enq_inst1.
REQ-006 enq_inst1  input  `INSN_LEN  first fetched instruction.
REQ-007 enq_inst2  input  `INSN_LEN  second fetched instruction; its PC is enq_pc+4.
REQ-008 enq_invalid2  input  1  enq_inst2 not valid; only enq_inst1 is enqueued.
REQ-009 enq_ready  output  1  queue can accept a bundle this cycle.
REQ-010 prmiss  input  1  branch mispredict; flush all contents.
REQ-011 dec_ready  input  1  decode consumes the presented instructions this cycle.
REQ-012 deq_valid1, deq_valid2  output  1 each  slot valid flags.
REQ-013 deq_inst1, deq_inst2  output  `INSN_LEN each  oldest and second-oldest instructions.
REQ-014 deq_pc1, deq_pc2  output  `ADDR_LEN each  PCs of deq_inst1/deq_inst2.

Function
REQ-015 The block SHALL be a circular FIFO of QUEUE_DEPTH entries, each entry {instruction, PC}, with head pointer, tail pointer and count of $clog2(QUEUE_DEPTH)+1 bits.
REQ-016 Enqueue fires when enq_valid && enq_ready && !prmiss; writes 2 entries (inst1 at tail, inst2 at tail+1), or 1 entry when enq_invalid2=1.
REQ-017 enq_ready SHALL be 1 iff QUEUE_DEPTH-count >= 2, computed from current count only (same-cycle dequeue is not credited).
REQ-018 deq_valid1 SHALL be (count>=1) && !prmiss; deq_valid2 SHALL be (count>=2) && !prmiss; deq_inst/pc SHALL be combinational reads of head and head+1.
REQ-019 Dequeue fires when dec_ready && deq_valid1; removes 2 entries if deq_valid2 else 1.
REQ-020 Next count SHALL be count + enq_n - deq_n; simultaneous enqueue and dequeue in one cycle SHALL both take effect.
REQ-021 Pointers SHALL wrap modulo QUEUE_DEPTH; a bundle straddling the wrap point SHALL store inst2 at index 0.
REQ-022 Latency: a bundle enqueued in cycle N SHALL be visible at deq outputs in cycle N+1 (bypass disabled).
REQ-023 prmiss SHALL have highest priority: next cycle head=tail=0, count=0; same-cycle enqueue and dequeue are discarded.
REQ-024 Instruction order SHALL be preserved exactly; no entry is lost or duplicated except by prmiss.
REQ-025 Storage contents SHALL not be reset; only pointers and count are.

Reset
REQ-026 While reset==0: head=0, tail=0, count=0, hence enq_ready=1, deq_valid1=0, deq_valid2=0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately; first enqueue after deassertion writes index 0.

Configuration
REQ-028 Macro FETCHQ_BYPASS_EN: when defined, if count==0 && enq_valid && !prmiss, the enq bundle SHALL drive deq outputs combinationally in the same cycle (deq_valid2 = !enq_invalid2); if dec_ready also 1, the bundle is consumed and not written; if dec_ready==0, it is written as normal.
REQ-029 When FETCHQ_BYPASS_EN is undefined, no combinational path from enq_* to deq_* SHALL exist.

Verification
REQ-030 Reset, then enq pc=0x100, inst1=0xA, inst2=0xB, dec_ready=0 -> next cycle deq_valid1=deq_valid2=1, deq_pc1=0x100, deq_pc2=0x104, count=2.
REQ-031 Enqueue 4 full bundles, dec_ready=0 -> count=8, enq_ready=0; further enq_valid ignored; then dec_ready=1 for 4 cycles -> PCs drain in order, count=0.
REQ-032 count=1, enq with enq_invalid2=1 and dec_ready=1 same cycle -> old entry leaves, new single entry remains, count=1, deq_valid2=0.
REQ-033 Fill to tail=7, enqueue 2-instruction bundle -> inst1 at index 7, inst2 at index 0; dequeue order correct.
REQ-034 Queue holding 6 entries, prmiss=1 with enq_valid=1 and dec_ready=1 -> deq_valid1=0 that cycle; next cycle count=0, enq_ready=1.
REQ-035 FETCHQ_BYPASS_EN defined, empty queue, enq pc=0x200 with dec_ready=1 -> same cycle deq_valid1=1, deq_pc1=0x200; next cycle count=0.
